// File: rtl/layernorm_stats_module.sv
// LayerNorm statistics producer: per-vector lane mean, saturated x-mean per
// lane, and floor(Q8.8 1/sqrt(var+EPS)) via a 16-step bit-serial search.
// Optional build macro: LN_RMS_MODE_EN selects RMSNorm mode (mean forced to 0,
// diff_out = x, var = mean(x^2)).
module layernorm_stats_module #(
    parameter int unsigned N   = 64,
    parameter int unsigned EPS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*16-1:0]   x_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*16-1:0]   diff_out,
    output logic [15:0]       inv_std
);

    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned LW    = 16;
    localparam int unsigned VW    = N * LW;
    localparam int unsigned ACCW  = 32 + LOG2N;
    localparam int unsigned CNTW  = LOG2N;
    localparam int unsigned BITW  = 4;
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(N - 1);
    localparam logic [63:0]     ISQRT_ONE = 64'h0000_0001_0000_0000;

    // S_LOAD is only reached in RMS mode; S_SUM/S_MEAN only in LayerNorm mode
    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_MEAN,
        S_LOAD,
        S_VAR,
        S_ISQRT,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [VW-1:0]       x_q, x_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [ACCW-1:0]     acc_q, acc_d;
    logic [31:0]         v_q, v_d;
    logic [LW-1:0]       y_q, y_d;
    logic [BITW-1:0]     bit_q, bit_d;
    logic [VW-1:0]       diff_d;
    logic [LW-1:0]       inv_d;
    logic                valid_d;

    // datapath intermediates
    logic signed [LW-1:0] lane_d;
    logic signed [31:0]   sq;
    logic [ACCW-1:0]      acc_add;
    logic [32:0]          v_wide;
    logic [LW-1:0]        yt;
    logic [31:0]          yt_sq;
    logic [63:0]          prod;
    logic                 keep;

`ifndef LN_RMS_MODE_EN
    localparam int unsigned SUMW = LW + LOG2N;

    logic signed [SUMW-1:0] sum_q, sum_d;
    logic signed [LW-1:0]   lane_x;
    logic signed [LW-1:0]   mean;
    logic [VW-1:0]          diff_all;

    // a - b clamped to the signed 16-bit range
    function automatic logic [LW-1:0] sat_sub(input logic signed [LW-1:0] a,
                                              input logic signed [LW-1:0] b);
        logic signed [LW:0] d;
        d = (LW+1)'(a) - (LW+1)'(b);
        if (d[LW] != d[LW-1])
            return d[LW] ? 16'h8000 : 16'h7FFF;
        return d[LW-1:0];
    endfunction

    // lane mean (floor division) and saturated differences for every lane
    always_comb begin
        lane_x   = x_q[{cnt_q, 4'h0} +: LW];
        mean     = LW'(sum_q >>> LOG2N);
        diff_all = '0;
        for (int i = 0; i < N; i++)
            diff_all[i*LW +: LW] = sat_sub(x_q[i*LW +: LW], mean);
    end
`endif

    assign in_ready = (state_q == S_IDLE);

    // next-state and next-value logic for all registered state
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        v_d     = v_q;
        y_d     = y_q;
        bit_d   = bit_q;
        diff_d  = diff_out;
        inv_d   = inv_std;
        valid_d = out_valid;
`ifndef LN_RMS_MODE_EN
        sum_d   = sum_q;
`endif

        lane_d  = diff_out[{cnt_q, 4'h0} +: LW];
        sq      = lane_d * lane_d;
        acc_add = acc_q + ACCW'($unsigned(sq));
        v_wide  = {1'b0, 32'(acc_add >> LOG2N)} + 33'(EPS);
        yt      = y_q | (LW'(1) << bit_q);
        yt_sq   = yt * yt;
        prod    = 64'(yt_sq) * 64'(v_q);
        keep    = (prod <= ISQRT_ONE);

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    x_d   = x_in;
                    cnt_d = '0;
                    acc_d = '0;
`ifndef LN_RMS_MODE_EN
                    sum_d   = '0;
                    state_d = S_SUM;
`else
                    state_d = S_LOAD;
`endif
                end
            end
`ifndef LN_RMS_MODE_EN
            S_SUM: begin
                sum_d = sum_q + SUMW'(lane_x);
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNT_LAST)
                    state_d = S_MEAN;
            end
            S_MEAN: begin
                diff_d  = diff_all;
                cnt_d   = '0;
                acc_d   = '0;
                state_d = S_VAR;
            end
`else
            S_LOAD: begin
                diff_d  = x_q;
                cnt_d   = '0;
                acc_d   = '0;
                state_d = S_VAR;
            end
`endif
            S_VAR: begin
                acc_d = acc_add;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNT_LAST) begin
                    v_d     = v_wide[32] ? 32'hFFFF_FFFF : v_wide[31:0];
                    y_d     = '0;
                    bit_d   = BITW'(15);
                    state_d = S_ISQRT;
                end
            end
            S_ISQRT: begin
                if (keep)
                    y_d = yt;
                bit_d = bit_q - BITW'(1);
                if (bit_q == '0) begin
                    inv_d   = keep ? yt : y_q;
                    valid_d = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // state register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            v_q       <= '0;
            y_q       <= '0;
            bit_q     <= '0;
            diff_out  <= '0;
            inv_std   <= '0;
            out_valid <= 1'b0;
`ifndef LN_RMS_MODE_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            v_q       <= v_d;
            y_q       <= y_d;
            bit_q     <= bit_d;
            diff_out  <= diff_d;
            inv_std   <= inv_d;
            out_valid <= valid_d;
`ifndef LN_RMS_MODE_EN
            sum_q     <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_layernorm_stats_module.sv
// Directed bench for layernorm_stats_module with N=4; two instances share the
// stimulus, one with EPS=1 and one with EPS=0.
module tb_layernorm_stats_module;

    localparam int unsigned N  = 4;
    localparam int unsigned VW = N * 16;
`ifdef LN_RMS_MODE_EN
    localparam int LAT       = 21;
    localparam int RST_EDGES = 3;
`else
    localparam int LAT       = 25;
    localparam int RST_EDGES = 6;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [VW-1:0] x_in;
    logic          out_ready;

    logic          in_ready_e1, out_valid_e1;
    logic [VW-1:0] diff_e1;
    logic [15:0]   inv_e1;
    logic          in_ready_e0, out_valid_e0;
    logic [VW-1:0] diff_e0;
    logic [15:0]   inv_e0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    layernorm_stats_module #(.N(N), .EPS(1)) u_dut_e1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e1),
        .x_in(x_in), .out_valid(out_valid_e1), .out_ready(out_ready),
        .diff_out(diff_e1), .inv_std(inv_e1)
    );

    layernorm_stats_module #(.N(N), .EPS(0)) u_dut_e0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e0),
        .x_in(x_in), .out_valid(out_valid_e0), .out_ready(out_ready),
        .diff_out(diff_e0), .inv_std(inv_e0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // present one vector, then wait (bounded) for out_valid; optionally complete the handshake
    task automatic run_case(input string tag, input logic [VW-1:0] x,
                            input logic [VW-1:0] exp_diff,
                            input logic [15:0] exp_inv_e0, input logic [15:0] exp_inv_e1,
                            input bit do_hs);
        int lat;
        @(negedge clk);
        x_in     = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = '0;
        check({tag, "_busy"}, 64'(in_ready_e0), 64'd0);
        lat = 0;
        while (!out_valid_e0 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(LAT));
        check({tag, "_vld_e1"}, 64'(out_valid_e1), 64'd1);
        check({tag, "_diff_e0"}, diff_e0, exp_diff);
        check({tag, "_diff_e1"}, diff_e1, exp_diff);
        check({tag, "_inv_e0"}, 64'(inv_e0), 64'(exp_inv_e0));
        check({tag, "_inv_e1"}, 64'(inv_e1), 64'(exp_inv_e1));
        if (do_hs) begin
            @(posedge clk);
            #1;
            check({tag, "_vld_drop"}, 64'(out_valid_e0), 64'd0);
            check({tag, "_rdy_back"}, 64'(in_ready_e0), 64'd1);
        end
    endtask

    localparam logic [VW-1:0] X1 = 64'h0100_0100_0100_0100;
    localparam logic [VW-1:0] X2 = 64'hFE00_0200_FE00_0200;
    localparam logic [VW-1:0] X3 = 64'h8000_7FFF_8000_7FFF;
    localparam logic [VW-1:0] X6 = 64'h0200_0200_0200_0200;

    initial begin
        logic [VW-1:0] hold_diff;
        logic [15:0]   hold_inv;
        int            stale;

        rst       = 1'b1;
        in_valid  = 1'b0;
        x_in      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", 64'(out_valid_e0), 64'd0);
        check("rst_diff", diff_e0, 64'd0);
        check("rst_inv", 64'(inv_e0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rdy", 64'(in_ready_e0), 64'd1);

`ifdef LN_RMS_MODE_EN
        run_case("t1", X1, X1, 16'h0100, 16'h00FF, 1'b1);
        run_case("t2", X2, X2, 16'h0080, 16'h007F, 1'b1);
        run_case("t3", X3, X3, 16'h0002, 16'h0002, 1'b1);
`else
        run_case("t1", X1, 64'd0, 16'hFFFF, 16'hFFFF, 1'b1);
        run_case("t2", X2, X2, 16'h0080, 16'h007F, 1'b1);
        run_case("t3", X3, 64'h8001_7FFF_8001_7FFF, 16'h0002, 16'h0002, 1'b1);
`endif

        // backpressure: outputs frozen while downstream stalls
        out_ready = 1'b0;
        run_case("t4", X2, X2, 16'h0080, 16'h007F, 1'b0);
        hold_diff = diff_e0;
        hold_inv  = inv_e0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t4_hold_vld", 64'(out_valid_e0), 64'd1);
            check("t4_hold_diff", diff_e0, hold_diff);
            check("t4_hold_inv", 64'(inv_e0), 64'(hold_inv));
            check("t4_hold_rdy", 64'(in_ready_e0), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_vld_drop", 64'(out_valid_e0), 64'd0);
        check("t4_rdy_back", 64'(in_ready_e0), 64'd1);

        // reset during the variance pass aborts the vector
        @(negedge clk);
        x_in     = X2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (RST_EDGES) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_vld", 64'(out_valid_e0), 64'd0);
        check("t5_rst_diff", diff_e0, 64'd0);
        check("t5_rst_inv", 64'(inv_e1), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_e0 || out_valid_e1)
                stale++;
        end
        check("t5_stale_vld", 64'(stale), 64'd0);
        check("t5_rdy", 64'(in_ready_e0), 64'd1);
        run_case("t5", X2, X2, 16'h0080, 16'h007F, 1'b1);

`ifdef LN_RMS_MODE_EN
        run_case("t6", X6, X6, 16'h0080, 16'h007F, 1'b1);
`else
        run_case("t6", X6, 64'd0, 16'hFFFF, 16'hFFFF, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
